branch_resolve_queue: RTL and testbench

In-order queue of in-flight predicted branches, sitting between fetch (which consults the global BHT) and execute (which resolves branches).
- Records PC and predicted direction at fetch.
- At resolution, compares the actual outcome with the prediction.
- Drives the global BHT update write (write / write_pc / taken).
- Raises a mispredict redirect and flushes all younger entries.

---
 rtl/branch_resolve_queue_pkg.sv | 16 +
 rtl/branch_resolve_queue_if.sv | 30 +++
 rtl/brq_entry_array.sv | 27 ++
 rtl/branch_resolve_queue.sv | 99 +++++++++
 tb/tb_branch_resolve_queue.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: PC word, queue entry and pointer.
package branch_resolve_queue_pkg;

  localparam int BRQ_DEPTH = 4;
  localparam int BRQ_PTR_W = 2;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     pred;
  } lc3b_brq_entry;

  typedef logic [BRQ_PTR_W-1:0] lc3b_brq_ptr;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bus of the branch resolve queue.
interface branch_resolve_queue_if
  import branch_resolve_queue_pkg::*;
#(
  parameter int PTR_W = BRQ_PTR_W
);
  logic           alloc;
  lc3b_word       alloc_pc;
  logic           alloc_pred;
  logic           full;
  logic           resolve;
  logic           resolve_taken;
  lc3b_word       resolve_target;
  logic           bht_write;
  lc3b_word       bht_write_pc;
  logic           bht_taken;
  logic           mispredict;
  lc3b_word       redirect_pc;
  logic [PTR_W:0] count;

  modport master (
    output alloc, alloc_pc, alloc_pred, resolve, resolve_taken, resolve_target,
    input  full, bht_write, bht_write_pc, bht_taken, mispredict, redirect_pc, count
  );

  modport slave (
    input  alloc, alloc_pc, alloc_pred, resolve, resolve_taken, resolve_target,
    output full, bht_write, bht_write_pc, bht_taken, mispredict, redirect_pc, count
  );
endinterface

// File: rtl/brq_entry_array.sv
// Entry storage: one synchronous write port at tail, one combinational read port at head.
module brq_entry_array
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PTR_W = BRQ_PTR_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  lc3b_brq_entry    wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output lc3b_brq_entry    rd_data
);

  lc3b_brq_entry mem [DEPTH];

  // Data is not reset; the owner tracks validity through its count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the oldest, updates the BHT and redirects on mispredict.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  branch_resolve_queue_if.slave bus
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic             bht_write_r;
  lc3b_word         bht_write_pc_r;
  logic             bht_taken_r;
  logic             mispredict_r;
  lc3b_word         redirect_pc_r;

  lc3b_brq_entry head_entry;
  lc3b_brq_entry alloc_entry;
  logic          full;
  logic          res_ok;
  logic          mis;
  logic          do_alloc;

  assign full        = (count_r == DEPTH_CNT);
  assign res_ok      = bus.resolve && (count_r != '0);
  assign mis         = res_ok && (head_entry.pred != bus.resolve_taken);
  // A mispredicting resolve makes a same-cycle alloc wrong-path, so it is dropped.
  assign do_alloc    = bus.alloc && (!full || res_ok) && !mis;
  assign alloc_entry = '{pc: bus.alloc_pc, pred: bus.alloc_pred};

  brq_entry_array #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_entries (
    .clk     (clk),
    .wr_en   (do_alloc),
    .wr_ptr  (tail_r),
    .wr_data (alloc_entry),
    .rd_ptr  (head_r),
    .rd_data (head_entry)
  );

  // Queue pointers, occupancy and the registered BHT/redirect outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r         <= '0;
      tail_r         <= '0;
      count_r        <= '0;
      bht_write_r    <= 1'b0;
      bht_write_pc_r <= 16'h0000;
      bht_taken_r    <= 1'b0;
      mispredict_r   <= 1'b0;
      redirect_pc_r  <= 16'h0000;
    end else if (res_ok) begin
      bht_write_r    <= 1'b1;
      bht_write_pc_r <= head_entry.pc;
      bht_taken_r    <= bus.resolve_taken;
      head_r         <= head_r + PTR_ONE;
      if (mis) begin
        mispredict_r  <= 1'b1;
        redirect_pc_r <= bus.resolve_taken ? bus.resolve_target : head_entry.pc + 16'd2;
        tail_r        <= head_r + PTR_ONE;
        count_r       <= '0;
      end else begin
        mispredict_r  <= 1'b0;
        tail_r        <= do_alloc ? tail_r + PTR_ONE : tail_r;
        count_r       <= do_alloc ? count_r : count_r - CNT_ONE;
      end
    end else begin
      bht_write_r  <= 1'b0;
      mispredict_r <= 1'b0;
      if (do_alloc) begin
        tail_r  <= tail_r + PTR_ONE;
        count_r <= count_r + CNT_ONE;
      end else begin
        tail_r  <= tail_r;
        count_r <= count_r;
      end
    end
  end

  assign bus.full         = full;
  assign bus.count        = count_r;
  assign bus.bht_write    = bht_write_r;
  assign bus.bht_write_pc = bht_write_pc_r;
  assign bus.bht_taken    = bht_taken_r;
  assign bus.mispredict   = mispredict_r;
  assign bus.redirect_pc  = redirect_pc_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_resolve_queue_if #(.PTR_W(2)) bus ();

  branch_resolve_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and return 1ns after the rising edge.
  task automatic drive(input logic a, input lc3b_word pc, input logic pred,
                       input logic r, input logic t, input lc3b_word tgt);
    bus.alloc          = a;
    bus.alloc_pc       = pc;
    bus.alloc_pred     = pred;
    bus.resolve        = r;
    bus.resolve_taken  = t;
    bus.resolve_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    chk("reset_count", 16'(bus.count), 16'd0);
    chk("reset_bht_write", 16'(bus.bht_write), 16'd0);
    chk("reset_mispredict", 16'(bus.mispredict), 16'd0);
    chk("reset_redirect_pc", bus.redirect_pc, 16'h0000);
    chk("reset_bht_write_pc", bus.bht_write_pc, 16'h0000);
    chk("reset_full", 16'(bus.full), 16'd0);
    reset = 1'b0;
    drive(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 16'h2002, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 16'h2004, 1'b1, 1'b1, 1'b1, 16'h0000);
    chk("pre_reset_count", 16'(bus.count), 16'd2);
    chk("pre_reset_bht_write", 16'(bus.bht_write), 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_count", 16'(bus.count), 16'd0);
    chk("async_reset_bht_write", 16'(bus.bht_write), 16'd0);
    chk("async_reset_mispredict", 16'(bus.mispredict), 16'd0);
    idle();
    reset = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("post_reset_resolve_bht_write", 16'(bus.bht_write), 16'd0);
    chk("post_reset_resolve_mispredict", 16'(bus.mispredict), 16'd0);
    chk("post_reset_resolve_count", 16'(bus.count), 16'd0);
  endtask

  task automatic test_correct();
    drive(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("correct_alloc_count", 16'(bus.count), 16'd1);
    chk("correct_alloc_no_write", 16'(bus.bht_write), 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h3040);
    chk("correct_bht_write", 16'(bus.bht_write), 16'd1);
    chk("correct_bht_write_pc", bus.bht_write_pc, 16'h3000);
    chk("correct_bht_taken", 16'(bus.bht_taken), 16'd1);
    chk("correct_mispredict", 16'(bus.mispredict), 16'd0);
    chk("correct_count", 16'(bus.count), 16'd0);
    idle();
    chk("correct_strobe_drop", 16'(bus.bht_write), 16'd0);
  endtask

  task automatic test_mispredict_not_taken();
    drive(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 16'h3002, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 16'h3004, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("nt_fill_count", 16'(bus.count), 16'd3);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h9999);
    chk("nt_bht_write", 16'(bus.bht_write), 16'd1);
    chk("nt_bht_write_pc", bus.bht_write_pc, 16'h3000);
    chk("nt_bht_taken", 16'(bus.bht_taken), 16'd0);
    chk("nt_mispredict", 16'(bus.mispredict), 16'd1);
    chk("nt_redirect_pc", bus.redirect_pc, 16'h3002);
    chk("nt_flush_count", 16'(bus.count), 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("nt_after_flush_no_write", 16'(bus.bht_write), 16'd0);
    chk("nt_after_flush_no_mispredict", 16'(bus.mispredict), 16'd0);
    chk("nt_redirect_hold", bus.redirect_pc, 16'h3002);
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h5000 + 16'(2 * i), 1'b1, 1'b0, 1'b0, 16'h0000);
    end
    chk("full_count", 16'(bus.count), 16'd4);
    chk("full_flag", 16'(bus.full), 16'd1);
    drive(1'b1, 16'h5008, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("full_drop_count", 16'(bus.count), 16'd4);
    drive(1'b1, 16'h500A, 1'b1, 1'b1, 1'b1, 16'h0000);
    chk("full_swap_count", 16'(bus.count), 16'd4);
    chk("full_swap_bht_write_pc", bus.bht_write_pc, 16'h5000);
    chk("full_swap_mispredict", 16'(bus.mispredict), 16'd0);
    chk("full_swap_redirect_hold", bus.redirect_pc, 16'h3002);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("full_drain0", bus.bht_write_pc, 16'h5002);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("full_drain1", bus.bht_write_pc, 16'h5004);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("full_drain2", bus.bht_write_pc, 16'h5006);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("full_drain3", bus.bht_write_pc, 16'h500A);
    chk("full_drain_count", 16'(bus.count), 16'd0);
    chk("full_drain_flag", 16'(bus.full), 16'd0);
  endtask

  task automatic test_taken_mispredict_collision();
    drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 16'h4000, 1'b1, 1'b1, 1'b1, 16'h1200);
    chk("tk_bht_write_pc", bus.bht_write_pc, 16'hFFFE);
    chk("tk_bht_taken", 16'(bus.bht_taken), 16'd1);
    chk("tk_mispredict", 16'(bus.mispredict), 16'd1);
    chk("tk_redirect_pc", bus.redirect_pc, 16'h1200);
    chk("tk_count", 16'(bus.count), 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("tk_alloc_dropped", 16'(bus.bht_write), 16'd0);
    drive(1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("wrap_redirect_pc", bus.redirect_pc, 16'h0000);
    chk("wrap_mispredict", 16'(bus.mispredict), 16'd1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h6000, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 16'h6000 + 16'(2 * i), 1'(i % 2), 1'b1, 1'((i - 1) % 2), 16'h0000);
      chk("b2b_pc", bus.bht_write_pc, 16'h6000 + 16'(2 * (i - 1)));
      chk("b2b_write", 16'(bus.bht_write), 16'd1);
      chk("b2b_mispredict", 16'(bus.mispredict), 16'd0);
      chk("b2b_count", 16'(bus.count), 16'd1);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("b2b_last_pc", bus.bht_write_pc, 16'h6012);
    chk("b2b_last_taken", 16'(bus.bht_taken), 16'd1);
    chk("b2b_empty_count", 16'(bus.count), 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("empty_resolve_no_write", 16'(bus.bht_write), 16'd0);
    chk("empty_resolve_pc_hold", bus.bht_write_pc, 16'h6012);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_correct();
    test_mispredict_not_taken();
    test_full();
    test_taken_mispredict_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
